// File: rtl/lmsm_pkg.sv
// Shared types and helpers for the LM/SM multi-register sequencer.
package lmsm_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_NREGS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2,
    DONE  = 2'd3
  } lmsm_state_e;

  // Index of the lowest set bit; 0 when the mask is empty (callers qualify with |mask).
  function automatic logic [2:0] lowest_set_idx(input logic [DEFAULT_NREGS-1:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = DEFAULT_NREGS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory request/acknowledge port shared by the sequencer and the memory side.
interface lmsm_sequencer_if
  import lmsm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lmsm_prio_enc.sv
// Combinational 8->3 lowest-set-bit priority encoder; picks the next register to move.
module lmsm_prio_enc
  import lmsm_pkg::*;
(
  input  logic [DEFAULT_NREGS-1:0] mask,
  output logic [2:0]               idx,
  output logic                     valid
);

  assign idx   = lowest_set_idx(mask);
  assign valid = |mask;

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM register-mask walker: moves one word per set mask bit between RF and memory.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREGS  = DEFAULT_NREGS
)(
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        rf_addr,
  output logic              rf_wen,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        xfer_count,
  lmsm_sequencer_if.master  mem
);

  lmsm_state_e       state;
  lmsm_state_e       next_state;
  logic              op;
  logic [ADDR_W-1:0] addr_ptr;
  logic [NREGS-1:0]  mask_rem;
  logic [NREGS-1:0]  cur_bit;
  logic [NREGS-1:0]  mask_cleared;
  logic [DATA_W-1:0] ld_data;
  logic [3:0]        xfer_cnt;
  logic [2:0]        cur_idx;
  logic              idx_valid;
  logic              last;

  lmsm_prio_enc u_prio_enc (
    .mask  (mask_rem),
    .idx   (cur_idx),
    .valid (idx_valid)
  );

  // Remaining mask once the register being serviced is retired.
  always_comb begin
    cur_bit          = '0;
    cur_bit[cur_idx] = 1'b1;
    mask_cleared     = idx_valid ? (mask_rem & ~cur_bit) : mask_rem;
  end

  assign last       = (mask_cleared == '0);
  assign xfer_count = xfer_cnt;

  // State register; reset forces IDLE so mem_req/rf_wen drop without a clock.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state: SM chains back-to-back issues, LM inserts a WB after each ack.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (reg_mask != '0) ? ISSUE : DONE;
      ISSUE:   if (mem.mem_ack) begin
                 if (op) next_state = last ? DONE : ISSUE;
                 else    next_state = WB;
               end
      WB:      next_state = last ? DONE : ISSUE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transfer context: captured at start, advanced on each completed word.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      op       <= 1'b0;
      addr_ptr <= '0;
      mask_rem <= '0;
      ld_data  <= '0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op       <= is_store;
          addr_ptr <= base_addr;
          mask_rem <= reg_mask;
          xfer_cnt <= '0;
        end
        ISSUE: if (mem.mem_ack) begin
          if (op) begin
            mask_rem <= mask_cleared;
            addr_ptr <= addr_ptr + ADDR_W'(1);
            xfer_cnt <= xfer_cnt + 4'd1;
          end else begin
            ld_data  <= mem.mem_rdata;
          end
        end
        WB: begin
          mask_rem <= mask_cleared;
          addr_ptr <= addr_ptr + ADDR_W'(1);
          xfer_cnt <= xfer_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from state so request and write-back never overlap.
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    rf_addr       = 3'd0;
    rf_wen        = 1'b0;
    rf_wdata      = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      ISSUE: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = op;
        mem.mem_addr  = addr_ptr;
        mem.mem_wdata = rf_rdata;
        rf_addr       = cur_idx;
      end
      WB: begin
        rf_wen   = 1'b1;
        rf_addr  = cur_idx;
        rf_wdata = ld_data;
      end
      default: ;
    endcase
  end

endmodule
